// File: rtl/debug_wb_pkg.sv
// Shared types for the debug Wishbone master, debug responder and host command decoder.
package debug_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wb_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_TIMEOUT = 2'd2
  } rsp_kind_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_cmd_t;

  // Only read acks carry data back; writes and errors report zero.
  function automatic logic [31:0] rsp_data(input logic we, input logic err,
                                           input logic [31:0] rdat);
    return (we || err) ? 32'h0 : rdat;
  endfunction

endpackage

// File: rtl/debug_wb_master_if.sv
// Command, response and Wishbone bus bundle for the debug master.
interface debug_wb_master_if;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o, rsp_timeout_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i, wb_ack_i, wb_err_i;
  logic [31:0] wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i, rsp_ready_i,
           wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter; expired_o is high once TIMEOUT_CYCLES enabled cycles have elapsed.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/debug_wb_master.sv
// Single-outstanding Wishbone pipelined initiator: one command in, one bus transfer,
// one response (read data, error or timeout) out.
module debug_wb_master
  import debug_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  debug_wb_master_if.master  bus
);
  wb_state_e   state_q, state_d;
  wb_cmd_t     cmd_q, cmd_d;
  rsp_kind_e   kind_q, kind_d;
  logic [31:0] rdat_q, rdat_d;
  logic        expired, accept, in_xfer, bus_rsp, take_rsp, take_tmo;

  assign accept   = (state_q == IDLE) && bus.cmd_valid_i;
  assign in_xfer  = (state_q == REQ) || (state_q == WAIT);
  assign bus_rsp  = bus.wb_ack_i || bus.wb_err_i;
  // A response only counts once the strobe has been taken by the slave.
  assign take_rsp = bus_rsp && (((state_q == REQ) && !bus.wb_stall_i) || (state_q == WAIT));
  assign take_tmo = in_xfer && expired && !take_rsp;

  wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_i),
    .clr_i     (accept),
    .en_i      (in_xfer),
    .expired_o (expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.cmd_valid_i) state_d = REQ;
      REQ: begin
        if (take_rsp || take_tmo) state_d = RESP;
        else if (!bus.wb_stall_i) state_d = WAIT;
      end
      WAIT: if (take_rsp || take_tmo) state_d = RESP;
      RESP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d  = cmd_q;
    kind_d = kind_q;
    rdat_d = rdat_q;
    if (accept) begin
      cmd_d  = '{we: bus.cmd_we_i, adr: bus.cmd_adr_i, dat: bus.cmd_dat_i, sel: bus.cmd_sel_i};
      kind_d = RSP_OK;
      rdat_d = '0;
    end
    if (take_rsp) begin
      kind_d = bus.wb_err_i ? RSP_ERR : RSP_OK;
      rdat_d = rsp_data(cmd_q.we, bus.wb_err_i, bus.wb_dat_i);
    end
    if (take_tmo) begin
      kind_d = RSP_TIMEOUT;
      rdat_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      cmd_q  <= '0;
      kind_q <= RSP_OK;
      rdat_q <= '0;
    end else begin
      cmd_q  <= cmd_d;
      kind_q <= kind_d;
      rdat_q <= rdat_d;
    end
  end

  // Response fields are only exposed while the response is being offered.
  always_comb begin
    bus.cmd_ready_o   = (state_q == IDLE);
    bus.wb_cyc_o      = in_xfer;
    bus.wb_stb_o      = (state_q == REQ);
    bus.wb_we_o       = cmd_q.we;
    bus.wb_adr_o      = cmd_q.adr;
    bus.wb_dat_o      = cmd_q.dat;
    bus.wb_sel_o      = cmd_q.sel;
    bus.rsp_valid_o   = (state_q == RESP);
    bus.rsp_dat_o     = (state_q == RESP) ? rdat_q : '0;
    bus.rsp_err_o     = (state_q == RESP) && (kind_q == RSP_ERR);
    bus.rsp_timeout_o = (state_q == RESP) && (kind_q == RSP_TIMEOUT);
  end
endmodule

// File: tb/tb_debug_wb_master.sv
// Bench for debug_wb_master: directed vector table, hand sequences for reset/latency,
// and randomized transfers checked against a timing/result model.
module tb_debug_wb_master;
  localparam int T = 8;
  localparam int MD_ACK = 0, MD_ERR = 1, MD_BOTH = 2, MD_NONE = 3;

  typedef struct {
    logic        we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    int          stall_n, ack_dly, mode, ready_dly;
  } txn_t;

  typedef struct {
    int          lat;
    logic [31:0] dat;
    logic        err, tmo, fld_bad;
    int          stb_n;
  } res_t;

  typedef struct { txn_t t; res_t e; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_wb_master_if bus();
  debug_wb_master #(.TIMEOUT_CYCLES(T)) dut (.wb_clk_i(clk), .wb_rst_i(rst_n), .bus(bus));

  int          nchk = 0, nerr = 0;
  logic [31:0] smem[16];
  logic [31:0] mmem[16];
  logic [7:0]  last_char = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int st, input int dl,
                              input int md, input int rd);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.sel = sel;
    t.stall_n = st; t.ack_dly = dl; t.mode = md; t.ready_dly = rd;
    return t;
  endfunction

  function automatic res_t mkr(input int lat, input logic [31:0] dat, input logic err,
                               input logic tmo, input int stb_n);
    res_t r;
    r.lat = lat; r.dat = dat; r.err = err; r.tmo = tmo; r.fld_bad = 1'b0; r.stb_n = stb_n;
    return r;
  endfunction

  // Model: the slave takes the strobe after stall_n stalled cycles and answers ack_dly
  // cycles later; anything not answered by cycle T+1 after the strobe rises times out.
  function automatic res_t predict(input txn_t t);
    res_t r;
    int acc   = t.stall_n + 1;
    int k_ack = acc + t.ack_dly;
    r.fld_bad = 1'b0;
    r.stb_n   = (acc <= T + 1) ? acc : T + 1;
    if (acc <= T + 1 && t.mode != MD_NONE && k_ack <= T + 1) begin
      r.lat = k_ack + 1;
      r.tmo = 1'b0;
      r.err = (t.mode != MD_ACK);
      r.dat = (r.err || t.we) ? 32'h0 : mmem[t.adr[5:2]];
    end else begin
      r.lat = T + 2; r.tmo = 1'b1; r.err = 1'b0; r.dat = 32'h0;
    end
    return r;
  endfunction

  task automatic commit(input txn_t t);
    if (t.we && t.mode == MD_ACK && t.stall_n + 1 <= T + 1)
      mmem[t.adr[5:2]] = merge(mmem[t.adr[5:2]], t.dat, t.sel);
  endtask

  // Drives one command and plays the slave; returns observed latency/result.
  task automatic run(input string tag, input txn_t t, output res_t r);
    int   idx, acc_k, stb_seen, rdy_cnt, k;
    bit   seen, done, prev_cyc;
    logic [31:0] s_dat;
    logic s_err, s_tmo;
    idx = int'(t.adr[5:2]);
    acc_k = -1; stb_seen = 0; rdy_cnt = 0; seen = 0; done = 0; prev_cyc = 0;
    r = mkr(0, 32'h0, 1'b0, 1'b0, 0);
    s_dat = 32'h0; s_err = 1'b0; s_tmo = 1'b0;
    chk($sformatf("%s cmd_ready", tag), {31'h0, bus.cmd_ready_o}, 32'h1);
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = t.we; bus.cmd_adr_i = t.adr;
    bus.cmd_dat_i = t.dat; bus.cmd_sel_i = t.sel;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    for (k = 1; k <= 60 && !done; k++) begin
      bus.wb_stall_i = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      bus.wb_dat_i = 32'h0; bus.rsp_ready_i = 1'b0;
      if (bus.wb_stb_o) begin
        stb_seen++;
        if (bus.wb_adr_o !== t.adr || bus.wb_we_o !== t.we || bus.wb_dat_o !== t.dat ||
            bus.wb_sel_o !== t.sel || bus.wb_cyc_o !== 1'b1) r.fld_bad = 1'b1;
        if (stb_seen <= t.stall_n) bus.wb_stall_i = 1'b1;
        else if (acc_k < 0) begin
          acc_k = k;
          if (t.we && t.mode == MD_ACK) smem[idx] = merge(smem[idx], t.dat, t.sel);
        end
      end
      if (acc_k > 0 && k == acc_k + t.ack_dly && t.mode != MD_NONE) begin
        bus.wb_ack_i = (t.mode != MD_ERR);
        bus.wb_err_i = (t.mode != MD_ACK);
        bus.wb_dat_i = (t.mode == MD_ACK && !t.we) ? smem[idx] : 32'hBADD_0BAD;
        if (t.we && t.mode == MD_ACK && t.adr == 32'h8000_0000) begin
          last_char = t.dat[7:0];
          $display("responder: %c", t.dat[7:0]);
        end
      end
      if (bus.rsp_valid_o) begin
        if (!seen) begin
          seen = 1; r.lat = k;
          s_dat = bus.rsp_dat_o; s_err = bus.rsp_err_o; s_tmo = bus.rsp_timeout_o;
          chk($sformatf("%s cyc_fall_with_rsp", tag), {30'h0, prev_cyc, bus.wb_cyc_o}, 32'h2);
        end else begin
          chk($sformatf("%s hold_dat", tag), bus.rsp_dat_o, s_dat);
          chk($sformatf("%s hold_flags", tag), {30'h0, bus.rsp_err_o, bus.rsp_timeout_o},
              {30'h0, s_err, s_tmo});
          chk($sformatf("%s busy_ready", tag), {31'h0, bus.cmd_ready_o}, 32'h0);
        end
        if (rdy_cnt == t.ready_dly) begin
          bus.rsp_ready_i = 1'b1;
          done = 1;
        end
        rdy_cnt++;
      end
      prev_cyc = bus.wb_cyc_o;
      @(posedge clk); #1;
    end
    bus.wb_stall_i = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    bus.wb_dat_i = 32'h0; bus.rsp_ready_i = 1'b0;
    r.dat = s_dat; r.err = s_err; r.tmo = s_tmo; r.stb_n = stb_seen;
    if (!seen) chk($sformatf("%s rsp_within_budget", tag), 32'h0, 32'h1);
    chk($sformatf("%s idle_after_hs", tag), {30'h0, bus.cmd_ready_o, bus.rsp_valid_o}, 32'h2);
  endtask

  task automatic apply(input string tag, input txn_t t, input res_t e);
    res_t r;
    run(tag, t, r);
    chk($sformatf("%s latency", tag), r.lat, e.lat);
    chk($sformatf("%s rsp_dat", tag), r.dat, e.dat);
    chk($sformatf("%s rsp_err", tag), {31'h0, r.err}, {31'h0, e.err});
    chk($sformatf("%s rsp_timeout", tag), {31'h0, r.tmo}, {31'h0, e.tmo});
    chk($sformatf("%s stb_cycles", tag), r.stb_n, e.stb_n);
    chk($sformatf("%s bus_fields", tag), {31'h0, r.fld_bad}, 32'h0);
    commit(t);
  endtask

  vec_t tbl[12];

  initial begin
    txn_t t;
    res_t e;
    bus.cmd_valid_i = 0; bus.cmd_we_i = 0; bus.cmd_adr_i = 0; bus.cmd_dat_i = 0;
    bus.cmd_sel_i = 0; bus.rsp_ready_i = 0; bus.wb_stall_i = 0; bus.wb_ack_i = 0;
    bus.wb_err_i = 0; bus.wb_dat_i = 0;
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      mmem[i] = smem[i];
    end
    smem[4] = 32'hDEAD_BEEF; mmem[4] = 32'hDEAD_BEEF;

    //               we  adr           dat           sel    st dl mode     rdy      lat dat           err tmo stb
    tbl[0]  = '{t: mk(1, 32'h8000_0000, 32'h0000_0041, 4'hF, 0, 1, MD_ACK,  0), e: mkr(3,  32'h0,         0, 0, 1)};
    tbl[1]  = '{t: mk(0, 32'h0000_0010, 32'h0,         4'hF, 3, 1, MD_ACK,  0), e: mkr(6,  32'hDEAD_BEEF, 0, 0, 4)};
    tbl[2]  = '{t: mk(0, 32'h0000_0020, 32'h0,         4'hF, 0, 1, MD_BOTH, 5), e: mkr(3,  32'h0,         1, 0, 1)};
    tbl[3]  = '{t: mk(0, 32'h0000_0024, 32'h0,         4'hF, 0, 0, MD_NONE, 0), e: mkr(10, 32'h0,         0, 1, 1)};
    tbl[4]  = '{t: mk(1, 32'h0000_0010, 32'h1234_5678, 4'h3, 1, 0, MD_ACK,  0), e: mkr(3,  32'h0,         0, 0, 2)};
    tbl[5]  = '{t: mk(0, 32'h0000_0010, 32'h0,         4'hF, 0, 0, MD_ACK,  0), e: mkr(2,  32'hDEAD_5678, 0, 0, 1)};
    tbl[6]  = '{t: mk(0, 32'h0000_0014, 32'h0,         4'hF, 0, 0, MD_ERR,  0), e: mkr(2,  32'h0,         1, 0, 1)};
    tbl[7]  = '{t: mk(0, 32'h0000_0010, 32'h0,         4'hF, 0, 8, MD_ACK,  0), e: mkr(10, 32'hDEAD_5678, 0, 0, 1)};
    tbl[8]  = '{t: mk(0, 32'h0000_0010, 32'h0,         4'hF, 0, 11, MD_ACK, 3), e: mkr(10, 32'h0,         0, 1, 1)};
    tbl[9]  = '{t: mk(0, 32'h0000_0010, 32'h0,         4'hF, 9, 1, MD_ACK,  0), e: mkr(10, 32'h0,         0, 1, 9)};
    tbl[10] = '{t: mk(0, 32'h0000_0010, 32'h0,         4'hF, 8, 0, MD_ACK,  0), e: mkr(10, 32'hDEAD_5678, 0, 0, 9)};
    tbl[11] = '{t: mk(1, 32'h8000_0000, 32'h0000_0050, 4'h1, 2, 1, MD_ACK,  1), e: mkr(5,  32'h0,         0, 0, 3)};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset cmd_ready", {31'h0, bus.cmd_ready_o}, 32'h1);
    chk("reset ctl", {25'h0, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o,
                      bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, 1'b0}, 32'h0);
    chk("reset rsp_dat", bus.rsp_dat_o, 32'h0);
    chk("reset wb_adr", bus.wb_adr_o, 32'h0);
    chk("reset wb_dat", bus.wb_dat_o, 32'h0);
    chk("reset wb_sel", {28'h0, bus.wb_sel_o}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].t, tbl[i].e);
      if (tbl[i].t.adr == 32'h8000_0000)
        chk($sformatf("vec%0d responder_char", i), {24'h0, last_char}, {24'h0, tbl[i].t.dat[7:0]});
    end

    // Reset while waiting for the slave
    bus.cmd_valid_i = 1'b1; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = 32'h30;
    bus.cmd_dat_i = 32'h0; bus.cmd_sel_i = 4'hF;
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rstmid in_wait", {30'h0, bus.wb_cyc_o, bus.wb_stb_o}, 32'h2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstmid cyc_stb", {30'h0, bus.wb_cyc_o, bus.wb_stb_o}, 32'h0);
    chk("rstmid rsp_ready", {30'h0, bus.rsp_valid_o, bus.cmd_ready_o}, 32'h1);
    chk("rstmid wb_adr", bus.wb_adr_o, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rstmid no_rsp", {30'h0, bus.rsp_valid_o, bus.wb_cyc_o}, 32'h0);
    end
    t = mk(1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, 0, 1, MD_ACK, 0);
    apply("post_reset_write", t, mkr(3, 32'h0, 1'b0, 1'b0, 1));

    // Randomized transfers against the model
    for (int n = 0; n < 40; n++) begin
      int m;
      t.we  = 1'($urandom_range(0, 1));
      t.adr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      t.dat = $urandom;
      t.sel = 4'($urandom_range(1, 15));
      t.stall_n = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
      t.ack_dly = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 3);
      m = $urandom_range(0, 9);
      t.mode = (m < 6) ? MD_ACK : (m == 6) ? MD_ERR : (m == 7) ? MD_BOTH : (m == 8) ? MD_NONE : MD_ACK;
      t.ready_dly = $urandom_range(0, 3);
      e = predict(t);
      apply($sformatf("rnd%0d", n), t, e);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/debug_wb_master.md
# debug_wb_master

Single-outstanding Wishbone pipelined initiator that turns one command (from a host-side debug link such as a UART command decoder or a testbench driver) into one bus read or write. It returns the bus result (read data, error, or timeout) on a response handshake. It sits beside the CPU as a second bus master, behind the interconnect arbiter, and drives the same slaves the core uses, including the character/pass-fail debug responder.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles from first `wb_stb_o` assertion to ack/err before the transfer is abandoned. Must be at least 1.

Ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous, active-low reset; 0 sampled at a clock edge resets the block
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  32  byte address
- cmd_dat_i  in  32  write data
- cmd_sel_i  in  4  byte lane selects
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  32  read data; 0 for writes, errors and timeouts
- rsp_err_o  out  1  slave signalled wb_err
- rsp_timeout_o  out  1  no ack/err within TIMEOUT_CYCLES
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone cycle, strobe and write enable
- wb_adr_o  out  32, wb_dat_o  out  32, wb_sel_o  out  4
- wb_stall_i, wb_ack_i, wb_err_i  in  1 each
- wb_dat_i  in  32

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i: latch we/adr/dat/sel, clear the timeout counter, go to REQ.
- REQ:
  - wb_cyc_o = wb_stb_o = 1 with the latched fields.
  - If wb_stall_i = 1: stay in REQ.
  - If wb_stall_i = 0: the request is accepted and the next state is WAIT.
  - If ack or err arrives in the same cycle the request is accepted, go straight to RESP.
- WAIT:
  - wb_cyc_o = 1, wb_stb_o = 0.
  - On wb_ack_i or wb_err_i: capture the result and go to RESP.
- RESP:
  - cyc/stb = 0 and rsp_valid_o = 1.
  - Response fields hold stable until rsp_ready_i, then the FSM returns to IDLE.
- Result capture:
  - err has priority over ack. Err sets rsp_err_o = 1 and rsp_dat_o = 0.
  - A read ack captures wb_dat_i. A write ack returns rsp_dat_o = 0.
- Timeout:
  - The counter increments every cycle in REQ and WAIT and saturates.
  - When it reaches TIMEOUT_CYCLES without ack/err: drop cyc/stb, set rsp_timeout_o = 1, go to RESP.
  - A late ack/err after that point is ignored.
- ack/err sampled in IDLE or RESP are ignored.
- Only one transfer is outstanding at any time; cmd_ready_o is 0 outside IDLE.

## Timing
- Reset values: state IDLE, cmd_ready_o = 1, rsp_valid_o = 0, and every other output 0 (all wb_* outputs, rsp_dat_o, rsp_err_o, rsp_timeout_o).
- Command accepted at edge N:
  - wb_cyc_o/wb_stb_o are high in cycle N+1.
  - With no stall, wb_stb_o is low in cycle N+2.
- Against a slave with registered ack (ack one cycle after an unstalled strobe):
  - ack is seen in cycle N+2.
  - rsp_valid_o is high in cycle N+3.
  - Command-to-response latency is 3 cycles.
- Each cycle of stall adds one cycle of latency.
- rsp_valid_o high and rsp_ready_i high at the same edge: the next cycle is IDLE with cmd_ready_o = 1. There is no back-to-back bypass, so a new command is accepted at the earliest one cycle after the response handshake.
- wb_cyc_o falls in the same edge that rsp_valid_o rises.
- Reset asserted mid-transfer: the next cycle is IDLE with all outputs at their reset values. cyc drops immediately and no response is produced.
- Timeout with TIMEOUT_CYCLES = T: rsp_timeout_o rises T+1 cycles after wb_stb_o first rises.

## Structure
- A shared package `debug_wb_pkg` holds the state enum (IDLE/REQ/WAIT/RESP) and the response-flag encodings. The debug responder and host command decoder reuse it.
- One sub-module: `wb_timeout_counter`, a saturating counter with clear/enable/expired and TIMEOUT_CYCLES as its parameter. Its width is $clog2(TIMEOUT_CYCLES+1).
- Everything else is inline in the FSM.

## Test plan
- Write adr 0x8000_0000, dat 0x0000_0041, sel 0xF to the debug responder (ack registered, no stall):
  - the responder prints 'A';
  - rsp_valid_o appears 3 cycles after acceptance with rsp_err_o = 0, rsp_timeout_o = 0, rsp_dat_o = 0.
- Read from a memory model holding 0xDEAD_BEEF with wb_stall_i held high for 3 cycles:
  - wb_stb_o stays high for 4 cycles with a constant address;
  - rsp_dat_o = 0xDEAD_BEEF and latency is 6 cycles.
- Slave asserts wb_err_i and wb_ack_i together:
  - rsp_err_o = 1 and rsp_dat_o = 0;
  - hold rsp_ready_i low for 5 cycles and check the response stays stable and cmd_ready_o = 0.
- Slave never responds, TIMEOUT_CYCLES = 8:
  - rsp_timeout_o = 1 exactly 9 cycles after stb rises and cyc drops;
  - a late ack 2 cycles later is ignored and the next command completes normally.
- wb_rst_i driven low while in WAIT:
  - next cycle cyc/stb = 0, rsp_valid_o = 0, cmd_ready_o = 1;
  - a subsequent write completes with the normal 3-cycle latency.
